// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (S1 operand register, S2 result/flag register).
// Optional feature: define ALU_PIPE_SLL_EN to enable opcode 000000 as logical left shift.
module alu_pipe #(
  parameter int NB_DATA_BUS = 8,
  parameter int NB_OPCODE   = 6
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [NB_DATA_BUS-1:0] i_first_operator,
  input  logic [NB_DATA_BUS-1:0] i_second_operator,
  input  logic [NB_OPCODE-1:0]   i_opcode,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NB_DATA_BUS-1:0] o_result,
  output logic                   o_zero,
  output logic                   o_neg,
  output logic                   o_carry,
  output logic                   o_overflow,
  output logic                   o_illegal
);

  localparam int MSB = NB_DATA_BUS - 1;

  localparam logic [NB_OPCODE-1:0] LP_OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] LP_OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] LP_OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] LP_OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] LP_OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] LP_OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] LP_OP_SRA = NB_OPCODE'(6'b000011);
  localparam logic [NB_OPCODE-1:0] LP_OP_SRL = NB_OPCODE'(6'b000010);
`ifdef ALU_PIPE_SLL_EN
  localparam logic [NB_OPCODE-1:0] LP_OP_SLL = NB_OPCODE'(6'b000000);
`endif

  // Shift amounts at or above the data width saturate rather than wrap.
  localparam logic [NB_DATA_BUS-1:0] LP_SHIFT_LIMIT = NB_DATA_BUS'(NB_DATA_BUS);

  // Stage 1: captured operation
  logic                   r_s1_valid;
  logic [NB_DATA_BUS-1:0] r_s1_a;
  logic [NB_DATA_BUS-1:0] r_s1_b;
  logic [NB_OPCODE-1:0]   r_s1_op;

  // Stage 2: registered result and flags
  logic                   r_s2_valid;
  logic [NB_DATA_BUS-1:0] r_s2_result;
  logic                   r_s2_zero;
  logic                   r_s2_neg;
  logic                   r_s2_carry;
  logic                   r_s2_overflow;
  logic                   r_s2_illegal;

  logic                   w_adv1;
  logic                   w_adv2;
  logic [NB_DATA_BUS:0]   w_sum;
  logic [NB_DATA_BUS:0]   w_diff;
  logic                   w_shift_sat;
  logic [NB_DATA_BUS-1:0] w_result;
  logic                   w_carry;
  logic                   w_overflow;
  logic                   w_illegal;
  logic                   w_zero;
  logic                   w_neg;

  // A stage may load when it is empty or when its contents move on this edge.
  assign w_adv2  = !r_s2_valid || i_ready;
  assign w_adv1  = !r_s1_valid || w_adv2;
  assign o_ready = w_adv1 && !i_reset;

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_result    = '0;
    w_carry     = 1'b0;
    w_overflow  = 1'b0;
    w_illegal   = 1'b0;
    w_shift_sat = (r_s1_b >= LP_SHIFT_LIMIT);

    case (r_s1_op)
      LP_OP_ADD: begin
        w_result   = w_sum[MSB:0];
        w_carry    = w_sum[NB_DATA_BUS];
        w_overflow = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum[MSB] != r_s1_a[MSB]);
      end
      LP_OP_SUB: begin
        w_result   = w_diff[MSB:0];
        w_carry    = w_diff[NB_DATA_BUS];
        w_overflow = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_diff[MSB] != r_s1_a[MSB]);
      end
      LP_OP_AND: w_result = r_s1_a & r_s1_b;
      LP_OP_OR:  w_result = r_s1_a | r_s1_b;
      LP_OP_XOR: w_result = r_s1_a ^ r_s1_b;
      LP_OP_NOR: w_result = ~(r_s1_a | r_s1_b);
      LP_OP_SRA: w_result = w_shift_sat ? {NB_DATA_BUS{r_s1_a[MSB]}}
                                        : NB_DATA_BUS'($signed(r_s1_a) >>> r_s1_b);
      LP_OP_SRL: w_result = w_shift_sat ? '0 : (r_s1_a >> r_s1_b);
`ifdef ALU_PIPE_SLL_EN
      LP_OP_SLL: w_result = w_shift_sat ? '0 : (r_s1_a << r_s1_b);
`endif
      default:   w_illegal = 1'b1;
    endcase

    w_zero = (w_result == '0);
    w_neg  = w_result[MSB];
  end

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_a  <= i_first_operator;
        r_s1_b  <= i_second_operator;
        r_s1_op <= i_opcode;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    // NOTE: result registers are reset too, because they drive the outputs directly and must read 0 after reset.
    if (i_reset) begin
      r_s2_valid    <= 1'b0;
      r_s2_result   <= '0;
      r_s2_zero     <= 1'b0;
      r_s2_neg      <= 1'b0;
      r_s2_carry    <= 1'b0;
      r_s2_overflow <= 1'b0;
      r_s2_illegal  <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result   <= w_result;
        r_s2_zero     <= w_zero;
        r_s2_neg      <= w_neg;
        r_s2_carry    <= w_carry;
        r_s2_overflow <= w_overflow;
        r_s2_illegal  <= w_illegal;
      end
    end
  end

  assign o_valid    = r_s2_valid;
  assign o_result   = r_s2_result;
  assign o_zero     = r_s2_zero;
  assign o_neg      = r_s2_neg;
  assign o_carry    = r_s2_carry;
  assign o_overflow = r_s2_overflow;
  assign o_illegal  = r_s2_illegal;

endmodule
